hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the decode→execute boundary. Compares decode-stage source registers against execute- and memory-stage destinations and produces the forward selects, stall, flush and execute-hold controls consumed by the DX pipeline register and the front end. It sequences multi-cycle execute operations with a small FSM and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- ADDR_W, 5, register address width; address 0 is the hard-wired zero register
- MUL_LAT, 4, execute-stage occupancy in cycles of a multi-cycle op; legal range 1..16
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk externally)
- d_rs_a, d_rt_a  in  ADDR_W  decode-stage source addresses
- d_uses_rs, d_uses_rt  in  1  decode instruction actually reads rs / rt
- x_rd_a  in  ADDR_W  execute-stage destination
- x_reg_write, x_mem_read  in  1  execute instruction writes a register / is a load
- x_multi  in  1  execute instruction is a multi-cycle op
- x_jump  in  1  execute stage resolved a taken branch/jump
- m_rd_a  in  ADDR_W  memory-stage destination
- m_reg_write  in  1  memory instruction writes a register
- m_busy  in  1  data memory not ready; whole pipeline freezes
- fwdX_rs, fwdX_rt  out  1  select execute-stage result for rs / rt
- fwdM_rs, fwdM_rt  out  1  select memory-stage result for rs / rt
- stall  out  1  hold fetch/decode, inject bubble into execute register
- flush  out  1  kill decode-stage instruction (becomes bubble)
- x_hold  out  1  hold execute-stage register contents
- stall_cnt  out  16  saturating count of cycles with stall=1

## Operation
- Match(src, dst) = uses_src && src!=0 && src==dst.
- fwdX_s = Match(d_s_a, x_rd_a) && x_reg_write && !x_mem_read. fwdM_s = Match(d_s_a, m_rd_a) && m_reg_write && !fwdX_s (execute has priority). All four forced 0 whenever stall=1.
- load_use = x_mem_read && x_reg_write && (Match(d_rs_a,x_rd_a) || Match(d_rt_a,x_rd_a)).
- FSM states RUN, MULTI; 4-bit counter cnt.
  - RUN: if x_multi && MUL_LAT>1 && !m_busy: x_hold=1, next MULTI, cnt<=MUL_LAT-2. Else stay RUN.
  - MULTI: x_multi and x_jump ignored. If cnt!=0: x_hold=1, cnt<=cnt-1 (when !m_busy). If cnt==0: x_hold=0, next RUN (when !m_busy).
  - Net: x_hold high for exactly MUL_LAT-1 consecutive non-frozen cycles starting the cycle x_multi is first seen; low in the final execute cycle.
- Priority (highest first) for stall/flush/x_hold:
  1. m_busy=1: stall=1, x_hold=1, flush=0; FSM state, cnt frozen.
  2. x_jump && !x_hold: flush=1, stall=0 (wrong-path load-use ignored).
  3. x_hold=1: stall=1, flush=0.
  4. load_use: stall=1 for one cycle; next cycle load is in memory stage and fwdM covers it.
  5. Otherwise stall=flush=0.
- stall_cnt increments by 1 on each clock edge where stall=1; holds at 16'hFFFF.

## Timing
- Forward selects, stall, flush, x_hold are combinational from inputs and current state; consumed at the same clock edge.
- Reset (rst=0): state=RUN, cnt=0, stall_cnt=0 immediately; combinational outputs then follow inputs under RUN.
- Reset mid-MULTI aborts the op: state returns to RUN, x_hold drops asynchronously.
- Load-use: exactly one bubble cycle; back-to-back load-use on consecutive loads gives one bubble each.
- MUL_LAT=1: never leaves RUN, x_hold never asserted by x_multi.
- x_multi and x_jump same cycle in RUN: treat as multi (x_hold=1 blocks jump); jump not expected on a multi op.
- m_busy asserted during MULTI extends hold by the number of busy cycles; cnt does not decrement.

## Test plan
- d_rs_a=3, d_uses_rs=1, x_rd_a=3, x_reg_write=1, m_rd_a=3, m_reg_write=1 -> fwdX_rs=1, fwdM_rs=0; same with d_rs_a=0 -> both 0.
- Load x_rd_a=5, x_mem_read=1; decode d_rt_a=5 -> stall=1 one cycle, stall_cnt 0→1; next cycle m_rd_a=5, m_reg_write=1 -> fwdM_rt=1, stall=0.
- MUL_LAT=4, x_multi=1 at cycle T -> x_hold=stall=1 at T, T+1, T+2; both 0 at T+3; RUN at T+4.
- Same as above with m_busy=1 at T+1 for 2 cycles -> x_hold high T..T+4, low T+5.
- x_jump=1 with concurrent load_use -> flush=1, stall=0; assert rst=0 during MULTI -> x_hold=0 immediately, stall_cnt=0.
- Hold stall=1 for 70000 cycles -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the pipeline (decode/execute/memory stage status) and the
//   hazard controller (forward selects, stall/flush/hold, stall counter).
//
//   master : pipeline side, drives stage status, consumes hazard controls
//   slave  : hazard controller side
//
//   d_rs_a, d_rt_a        decode-stage source register addresses
//   d_uses_rs, d_uses_rt  decode instruction reads rs / rt
//   x_rd_a                execute-stage destination address
//   x_reg_write           execute instruction writes a register
//   x_mem_read            execute instruction is a load
//   x_multi               execute instruction is a multi-cycle op
//   x_jump                execute resolved a taken branch/jump
//   m_rd_a, m_reg_write   memory-stage destination / write enable
//   m_busy                data memory not ready, pipeline frozen
//   fwdX_rs, fwdX_rt      forward execute-stage result to rs / rt
//   fwdM_rs, fwdM_rt      forward memory-stage result to rs / rt
//   stall, flush, x_hold  pipeline control
//   stall_cnt             saturating stall-cycle counter
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] d_rs_a;
   logic [ADDR_W-1:0] d_rt_a;
   logic              d_uses_rs;
   logic              d_uses_rt;
   logic [ADDR_W-1:0] x_rd_a;
   logic              x_reg_write;
   logic              x_mem_read;
   logic              x_multi;
   logic              x_jump;
   logic [ADDR_W-1:0] m_rd_a;
   logic              m_reg_write;
   logic              m_busy;
   logic              fwdX_rs;
   logic              fwdX_rt;
   logic              fwdM_rs;
   logic              fwdM_rt;
   logic              stall;
   logic              flush;
   logic              x_hold;
   logic [15:0]       stall_cnt;

   modport master (
      output d_rs_a, d_rt_a, d_uses_rs, d_uses_rt,
      output x_rd_a, x_reg_write, x_mem_read, x_multi, x_jump,
      output m_rd_a, m_reg_write, m_busy,
      input  fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt,
      input  stall, flush, x_hold, stall_cnt
   );

   modport slave (
      input  d_rs_a, d_rt_a, d_uses_rs, d_uses_rt,
      input  x_rd_a, x_reg_write, x_mem_read, x_multi, x_jump,
      input  m_rd_a, m_reg_write, m_busy,
      output fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt,
      output stall, flush, x_hold, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for the decode->execute boundary. Resolves register
//   forwarding from the execute and memory stages, detects load-use hazards,
//   sequences multi-cycle execute ops (RUN/MULTI FSM), squashes the decode
//   instruction on a taken jump and counts stall cycles.
//
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   hif  : hazard_ctrl_if.slave (stage status in, hazard controls out)
//
//   Forward selects, stall, flush and x_hold are combinational from the
//   current inputs and FSM state.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int ADDR_W  = 5,
   parameter int MUL_LAT = 4
) (
   input  logic               clk,
   input  logic               rst,
   hazard_ctrl_if.slave       hif
);

   typedef enum logic {RUN, MULTI} state_t;

   // Counter preload: the first hold cycle happens in RUN, so MULTI only
   // has to cover MUL_LAT-2 more hold cycles before its final release cycle.
   localparam int         CNT_INIT_I = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
   localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];
   localparam bit         MULTI_EN   = (MUL_LAT > 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [15:0] stall_cnt;

   logic hold_fsm;
   logic jump_ok;
   logic load_use;
   logic fx_rs, fx_rt, fm_rs, fm_rt;
   logic stall, flush, x_hold;

   function automatic logic match(input logic              use_src,
                                  input logic [ADDR_W-1:0] src,
                                  input logic [ADDR_W-1:0] dst);
      return use_src && (src != '0) && (src == dst);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Raw forwarding candidates; execute stage wins over memory stage.
   always_comb begin
      fx_rs = match(hif.d_uses_rs, hif.d_rs_a, hif.x_rd_a) &&
              hif.x_reg_write && !hif.x_mem_read;
      fx_rt = match(hif.d_uses_rt, hif.d_rt_a, hif.x_rd_a) &&
              hif.x_reg_write && !hif.x_mem_read;
      fm_rs = match(hif.d_uses_rs, hif.d_rs_a, hif.m_rd_a) &&
              hif.m_reg_write && !fx_rs;
      fm_rt = match(hif.d_uses_rt, hif.d_rt_a, hif.m_rd_a) &&
              hif.m_reg_write && !fx_rt;
      load_use = hif.x_mem_read && hif.x_reg_write &&
                 (match(hif.d_uses_rs, hif.d_rs_a, hif.x_rd_a) ||
                  match(hif.d_uses_rt, hif.d_rt_a, hif.x_rd_a));
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // FSM next state plus the hold request it raises. m_busy freezes
   // state and counter, so every transition is gated by !m_busy.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hold_fsm  = 1'b0;
      case (state)
         RUN: begin
            if (hif.x_multi && MULTI_EN) begin
               hold_fsm = 1'b1;
               if (!hif.m_busy) begin
                  state_nxt = MULTI;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         MULTI: begin
            if (cnt != 4'd0) begin
               hold_fsm = 1'b1;
               if (!hif.m_busy) cnt_nxt = cnt - 4'd1;
            end else if (!hif.m_busy) begin
               state_nxt = RUN;
            end
         end
      endcase
   end

   // Control priority: memory freeze, taken jump, multi-cycle hold,
   // load-use bubble. A jump seen while MULTI is active (or alongside a
   // new multi op) is not acted on.
   always_comb begin
      stall   = 1'b0;
      flush   = 1'b0;
      x_hold  = 1'b0;
      jump_ok = hif.x_jump && (state == RUN) && !hold_fsm;
      if (hif.m_busy) begin
         stall  = 1'b1;
         x_hold = 1'b1;
      end else if (jump_ok) begin
         flush  = 1'b1;
      end else if (hold_fsm) begin
         stall  = 1'b1;
         x_hold = 1'b1;
      end else if (load_use) begin
         stall  = 1'b1;
      end
   end

   // Stall-cycle counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       stall_cnt <= 16'd0;
      else if (stall) stall_cnt <= sat_inc(stall_cnt);
   end

   // Forwarding is meaningless while decode is held, so it is suppressed.
   assign hif.fwdX_rs   = fx_rs && !stall;
   assign hif.fwdX_rt   = fx_rt && !stall;
   assign hif.fwdM_rs   = fm_rs && !stall;
   assign hif.fwdM_rt   = fm_rt && !stall;
   assign hif.stall     = stall;
   assign hif.flush     = flush;
   assign hif.x_hold    = x_hold;
   assign hif.stall_cnt = stall_cnt;

endmodule
